// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: FSM states, ALU function
// encoding and the opcode/funct values of the supported instruction subset.
package mips_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
    } alu_fn_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, register 0 reads as zero and ignores writes.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0)
            regs[waddr] <= wdata;
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB FSM with req/ready
// instruction and data ports; ALU and instruction decode are inline.
module mips_multicycle
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 32,
    parameter int          DMEM_AW  = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [31:0]        imem_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic               dmem_ready,
    input  logic [31:0]        dmem_rdata,
    output logic [31:0]        pc,
    output logic               retire,
    output logic               illegal
);

    state_t      state, state_next;
    logic [31:0] ir, npc, alu_out, mdr;
    logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_y, pc_target;
    logic signed [31:0] a_s, b_s;
    logic [5:0]  op, funct;
    logic [4:0]  rs_idx, rt_idx, rd_idx, shamt;
    logic [15:0] imm;
    alu_fn_t     alu_fn;
    logic        use_imm, imm_zext, dst_rd, wb_en, is_lw, is_sw;
    logic        is_beq, is_bne, is_j, is_jal, is_jr, bad, ends_exec, taken;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign op     = ir[31:26];
    assign rs_idx = ir[25:21];
    assign rt_idx = ir[20:16];
    assign rd_idx = ir[15:11];
    assign shamt  = ir[10:6];
    assign funct  = ir[5:0];
    assign imm    = ir[15:0];

    always_comb begin
        alu_fn = ALU_ADD; use_imm = 1'b0; imm_zext = 1'b0; dst_rd = 1'b0;
        wb_en = 1'b0; is_lw = 1'b0; is_sw = 1'b0; is_beq = 1'b0; is_bne = 1'b0;
        is_j = 1'b0; is_jal = 1'b0; is_jr = 1'b0; bad = 1'b0;
        case (op)
            OP_RTYPE: begin
                dst_rd = 1'b1;
                wb_en  = 1'b1;
                case (funct)
                    FN_ADD:  alu_fn = ALU_ADD;
                    FN_SUB:  alu_fn = ALU_SUB;
                    FN_AND:  alu_fn = ALU_AND;
                    FN_OR:   alu_fn = ALU_OR;
                    FN_SLT:  alu_fn = ALU_SLT;
                    FN_SLL:  alu_fn = ALU_SLL;
                    FN_SRL:  alu_fn = ALU_SRL;
                    FN_JR:   begin is_jr = 1'b1; wb_en = 1'b0; end
                    default: begin bad = 1'b1; wb_en = 1'b0; end
                endcase
            end
            OP_ADDI: begin use_imm = 1'b1; wb_en = 1'b1; end
            OP_SLTI: begin use_imm = 1'b1; wb_en = 1'b1; alu_fn = ALU_SLT; end
            OP_ANDI: begin use_imm = 1'b1; wb_en = 1'b1; imm_zext = 1'b1; alu_fn = ALU_AND; end
            OP_ORI:  begin use_imm = 1'b1; wb_en = 1'b1; imm_zext = 1'b1; alu_fn = ALU_OR; end
            OP_LUI:  begin wb_en = 1'b1; alu_fn = ALU_LUI; end
            OP_LW:   begin use_imm = 1'b1; wb_en = 1'b1; is_lw = 1'b1; end
            OP_SW:   begin use_imm = 1'b1; is_sw = 1'b1; end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_j = 1'b1;
            OP_JAL:  is_jal = 1'b1;
            default: bad = 1'b1;
        endcase
    end

    assign imm_ext = imm_zext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    assign alu_b   = use_imm ? imm_ext : rt_val;
    assign a_s     = rs_val;
    assign b_s     = alu_b;

    always_comb begin
        alu_y = rs_val + alu_b;
        case (alu_fn)
            ALU_ADD: alu_y = rs_val + alu_b;
            ALU_SUB: alu_y = rs_val - alu_b;
            ALU_AND: alu_y = rs_val & alu_b;
            ALU_OR:  alu_y = rs_val | alu_b;
            ALU_SLT: alu_y = {31'd0, a_s < b_s};
            ALU_SLL: alu_y = alu_b << shamt;
            ALU_SRL: alu_y = alu_b >> shamt;
            ALU_LUI: alu_y = {imm, 16'h0000};
            default: alu_y = rs_val + alu_b;
        endcase
    end

    // npc already holds PC+4 once DECODE has run; non-control instructions fall through to it
    assign taken     = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val);
    assign ends_exec = bad || is_beq || is_bne || is_j || is_jal || is_jr;

    always_comb begin
        pc_target = npc;
        if (taken)
            pc_target = npc + {{14{imm[15]}}, imm, 2'b00};
        else if (is_j || is_jal)
            pc_target = {npc[31:28], ir[25:0], 2'b00};
        else if (is_jr)
            pc_target = rs_val;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            if (state_next == FETCH && state != FETCH)
                pc <= pc_target;
        end
    end

    // Handshake outputs are forced low while reset is held so a pending request drops at once
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state)
            FETCH: begin
                imem_req = reset;
                if (imem_ready) state_next = DECODE;
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                if (ends_exec) begin
                    state_next = FETCH;
                    retire     = reset;
                    illegal    = reset && bad;
                end else if (is_lw || is_sw) begin
                    state_next = MEM;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                dmem_req = reset;
                dmem_we  = reset && is_sw;
                if (dmem_ready) begin
                    state_next = is_lw ? WB : FETCH;
                    retire     = reset && is_sw;
                end
            end
            WB: begin
                state_next = FETCH;
                retire     = reset;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (imem_req && imem_ready) ir <= imem_rdata;
        if (state == DECODE) npc <= pc + 32'd4;
        if (state == EXEC) alu_out <= alu_y;
        if (dmem_req && dmem_ready) mdr <= dmem_rdata;
    end

    assign rf_we    = reset && ((state == WB && wb_en) || (state == EXEC && is_jal));
    assign rf_waddr = is_jal ? 5'd31 : (dst_rd ? rd_idx : rt_idx);
    assign rf_wdata = is_jal ? npc : (is_lw ? mdr : alu_out);

    mips_regfile u_regfile (
        .clk     (clk),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs_idx),
        .raddr_b (rt_idx),
        .rdata_a (rs_val),
        .rdata_b (rt_val)
    );

    assign imem_addr  = pc[IMEM_AW-1:0];
    assign dmem_addr  = alu_out[DMEM_AW-1:0];
    assign dmem_wdata = rt_val;

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: one program covering ALU ops, memory,
// branches, jumps and illegal opcodes, plus a reset-during-fetch scenario.
module tb_mips_multicycle;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, illegal;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          rel = 0;
    int          dmem_wait = 3;
    int          dw_cnt = 3;
    int          unstable = 0;
    logic        imem_hold = 1'b0;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:63];
    logic [31:0] ret_pc[$];
    int          ret_cyc[$];
    logic        ret_ill[$];
    logic [31:0] st_addr[$];
    logic [31:0] st_data[$];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_st_addr[14];
    logic [31:0] exp_st_data[14];

    mips_multicycle dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .pc         (pc),
        .retire     (retire),
        .illegal    (illegal)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    // Memory responders drive at the falling edge; monitors sample 1ns later
    initial begin
        logic [31:0] p_addr, p_wdata;
        logic        p_req, p_we;
        imem_ready = 1'b0; imem_rdata = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
        p_req = 1'b0; p_addr = 32'd0; p_wdata = 32'd0; p_we = 1'b0;
        forever begin
            @(negedge clk);
            imem_ready = imem_req && !imem_hold;
            imem_rdata = imem[imem_addr[9:2]];
            dmem_ready = 1'b0;
            if (dmem_req) begin
                if (dw_cnt == 0) begin
                    dmem_ready = 1'b1;
                    dw_cnt     = dmem_wait;
                    if (dmem_we) begin
                        dmem[dmem_addr[7:2]] = dmem_wdata;
                        st_addr.push_back(dmem_addr);
                        st_data.push_back(dmem_wdata);
                    end else begin
                        dmem_rdata = dmem[dmem_addr[7:2]];
                    end
                end else begin
                    dw_cnt--;
                end
            end else begin
                dw_cnt = dmem_wait;
            end
            #1;
            if (retire) begin
                ret_pc.push_back(pc);
                ret_cyc.push_back(cyc - rel + 1);
                ret_ill.push_back(illegal);
            end
            if (dmem_req && p_req && (dmem_addr != p_addr || dmem_wdata != p_wdata || dmem_we != p_we))
                unstable++;
            p_req = dmem_req; p_addr = dmem_addr; p_wdata = dmem_wdata; p_we = dmem_we;
        end
    end

    task automatic load_prog();
        for (int i = 0; i < 256; i++) imem[i] = 32'd0;
        for (int i = 0; i < 64; i++) dmem[i] = 32'd0;
        imem[0]  = enc_i(6'h08, 0, 1, 16'd5);
        imem[1]  = enc_i(6'h08, 0, 2, 16'd7);
        imem[2]  = enc_r(6'h20, 1, 2, 3, 0);
        imem[3]  = enc_i(6'h2B, 0, 3, 16'h10);
        imem[4]  = enc_i(6'h23, 0, 4, 16'h10);
        imem[5]  = enc_i(6'h2B, 0, 4, 16'h14);
        imem[6]  = enc_r(6'h22, 1, 2, 5, 0);
        imem[7]  = enc_r(6'h2A, 5, 1, 6, 0);
        imem[8]  = enc_r(6'h00, 0, 1, 7, 4);
        imem[9]  = enc_r(6'h02, 0, 5, 8, 28);
        imem[10] = enc_i(6'h0F, 0, 9, 16'h8001);
        imem[11] = enc_i(6'h0D, 9, 9, 16'hF0F0);
        imem[12] = enc_i(6'h0C, 5, 10, 16'hFFF0);
        imem[13] = enc_i(6'h0A, 5, 11, 16'hFFFF);
        imem[14] = enc_r(6'h24, 9, 10, 12, 0);
        imem[15] = enc_r(6'h25, 1, 2, 13, 0);
        imem[16] = enc_i(6'h08, 0, 0, 16'd9);
        for (int r = 5; r <= 13; r++)
            imem[12 + r] = enc_i(6'h2B, 0, 5'(r), 16'(32'h20 + 4 * (r - 5)));
        imem[26] = enc_i(6'h2B, 0, 0, 16'h44);
        imem[27] = enc_i(6'h05, 1, 2, 16'd2);
        imem[28] = enc_i(6'h08, 0, 2, 16'd99);
        imem[29] = enc_i(6'h08, 0, 2, 16'd99);
        imem[30] = enc_i(6'h04, 1, 2, 16'd2);
        imem[31] = enc_j(6'h03, 26'h40);
        imem[32] = 32'hFC22_0005;
        imem[33] = enc_r(6'h3F, 1, 1, 2, 0);
        imem[34] = enc_i(6'h2B, 0, 2, 16'h4C);
        imem[35] = enc_j(6'h02, 26'h23);
        imem[64] = enc_i(6'h2B, 0, 31, 16'h48);
        imem[65] = enc_r(6'h08, 31, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] sd [14];
        sd = '{32'd12, 32'd12, 32'hFFFF_FFFE, 32'd1, 32'h50, 32'hF, 32'h8001_F0F0,
               32'h0000_FFF0, 32'd1, 32'h0000_F0F0, 32'd7, 32'd0, 32'h80, 32'd7};
        exp_st_data = sd;
        exp_st_addr = '{32'h10, 32'h14, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h30,
                        32'h34, 32'h38, 32'h3C, 32'h40, 32'h44, 32'h48, 32'h4C};
        for (int i = 0; i < 28; i++) exp_pc.push_back(32'(4 * i));
        exp_pc.push_back(32'h78); exp_pc.push_back(32'h7C); exp_pc.push_back(32'h100);
        exp_pc.push_back(32'h104); exp_pc.push_back(32'h80); exp_pc.push_back(32'h84);
        exp_pc.push_back(32'h88); exp_pc.push_back(32'h8C);

        reset = 1'b0;
        load_prog();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);

        @(posedge clk); #1;
        reset = 1'b1;
        rel   = cyc;
        #1 chk("first_imem_req", {31'd0, imem_req}, 32'd1);

        for (int i = 0; i < 3000 && ret_pc.size() < 36; i++) @(posedge clk);
        chk("n_retired", (ret_pc.size() >= 36) ? 32'd36 : 32'(ret_pc.size()), 32'd36);
        if (ret_pc.size() >= 36) begin
            for (int i = 0; i < 36; i++) begin
                chk($sformatf("ret_pc[%0d]", i), ret_pc[i], exp_pc[i]);
                chk($sformatf("ret_ill[%0d]", i), {31'd0, ret_ill[i]},
                    (i == 32 || i == 33) ? 32'd1 : 32'd0);
            end
            chk("cyc_addi1", 32'(ret_cyc[0]), 32'd4);
            chk("cyc_addi2", 32'(ret_cyc[1]), 32'd8);
            chk("cyc_add",   32'(ret_cyc[2]), 32'd12);
            chk("cyc_sw",    32'(ret_cyc[3]), 32'd19);
            chk("lat_lw",    32'(ret_cyc[4] - ret_cyc[3]), 32'd8);
            chk("lat_bne",   32'(ret_cyc[27] - ret_cyc[26]), 32'd3);
            chk("lat_beq",   32'(ret_cyc[28] - ret_cyc[27]), 32'd3);
            chk("lat_jal",   32'(ret_cyc[29] - ret_cyc[28]), 32'd3);
            chk("lat_ill",   32'(ret_cyc[32] - ret_cyc[31]), 32'd3);
        end
        chk("n_stores", 32'(st_addr.size()), 32'd14);
        for (int i = 0; i < 14 && i < st_addr.size(); i++) begin
            chk($sformatf("st_addr[%0d]", i), st_addr[i], exp_st_addr[i]);
            chk($sformatf("st_data[%0d]", i), st_data[i], exp_st_data[i]);
        end
        chk("dmem_stable", 32'(unstable), 32'd0);

        // Park the core in FETCH with the fetch never completing, then reset it
        @(posedge clk); #1;
        imem_hold = 1'b1;
        for (int i = 0; i < 10 && !imem_req; i++) begin
            @(posedge clk); #2;
        end
        chk("hold_imem_req", {31'd0, imem_req}, 32'd1);
        chk("hold_pc", pc, 32'h8C);
        reset = 1'b0;
        @(posedge clk); #2;
        chk("rst2_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst2_pc", pc, 32'h0);
        @(posedge clk); #1;
        ret_pc.delete(); ret_cyc.delete(); ret_ill.delete();
        imem_hold = 1'b0;
        reset     = 1'b1;
        rel       = cyc;
        #1;
        chk("rel2_imem_req", {31'd0, imem_req}, 32'd1);
        chk("rel2_imem_addr", imem_addr, 32'h0);
        for (int i = 0; i < 50 && ret_pc.size() < 1; i++) @(posedge clk);
        chk("rel2_retired", (ret_pc.size() >= 1) ? 32'd1 : 32'd0, 32'd1);
        if (ret_pc.size() >= 1) begin
            chk("rel2_ret_pc", ret_pc[0], 32'h0);
            chk("rel2_ret_cyc", 32'(ret_cyc[0]), 32'd4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
